serial_adder: RTL
=================

# serial_adder

Bit-serial two-operand adder that drives a single full-adder cell one bit per clock, LSB first, with the carry held in a flop between bits. Sits as the sequential stage around the gate-level full-adder cell. It loads parallel operands through a valid/ready handshake, iterates WIDTH cycles, and presents the parallel sum and carry-out through a second valid/ready handshake. It is an area-minimal alternative to a ripple adder in the gate-level benchmark set.

## Interface
Parameters:
- WIDTH, default 8: operand and sum width in bits. Legal range is 2 or more.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  operands a, b, cin are valid.
- start_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A, sampled at start handshake.
- b  input  WIDTH  operand B, sampled at start handshake.
- cin  input  1  carry-in, sampled at start handshake.
- sum  output  WIDTH  result; valid while done_valid is high.
- cout  output  1  final carry-out; valid while done_valid is high.
- done_valid  output  1  result available.
- done_ready  input  1  consumer accepts the result.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - start_ready=1.
  - On start_valid && start_ready: load shift registers a_sh←a, b_sh←b, carry←cin, sum_sh←0, bit counter cnt←0. Go to RUN.
- RUN, each cycle:
  - Full-adder cell evaluates s = a_sh[0]^b_sh[0]^carry and c = majority(a_sh[0], b_sh[0], carry).
  - carry←c.
  - a_sh and b_sh shift right by 1.
  - sum_sh shifts right with s inserted at bit WIDTH-1.
  - cnt←cnt+1.
  - When cnt==WIDTH-1, go to DONE after this update.
  - start_valid is ignored.
- DONE:
  - done_valid=1.
  - sum=sum_sh and cout=carry, both held stable.
  - On done_ready, go to IDLE. A start is not accepted in the same cycle; start_ready stays low until IDLE.
- Width rules:
  - cnt is $clog2(WIDTH) bits.
  - Exactly WIDTH bit-steps occur per operation.
  - sum is (a+b+cin) mod 2^WIDTH; cout is bit WIDTH of the true sum.
- Outputs outside DONE:
  - sum holds its previous result, or 0 after reset.
  - cout holds its previous value, or 0 after reset.
  - Consumers must qualify sum and cout with done_valid.

## Timing
- Reset values: state=IDLE, start_ready=1, done_valid=0, sum=0, cout=0, ovf=0. All internal registers are 0.
- Start handshake at edge E0. RUN occupies edges E1..E_WIDTH. done_valid rises after edge E_WIDTH. Latency from start accept to done_valid is WIDTH cycles.
- Throughput is at most one operation per WIDTH+2 cycles when done_ready is held high: WIDTH RUN cycles, 1 DONE cycle, 1 IDLE cycle.
- Backpressure: done_valid, sum, cout and ovf stay constant while done_ready=0, for an unbounded time.
- Reset mid-operation: an asynchronous assert from any state immediately forces reset values. The in-flight operation is discarded with no partial result.
- If done_ready is high before DONE, it has no effect.
- start_valid and the operands may change freely outside the accept cycle.

## Configuration
SERIAL_ADDER_OVF_EN:
- Defined:
  - Adds the ovf output port.
  - A flop captures the carry into the MSB, i.e. carry before the last bit-step.
  - In DONE, ovf = carry_into_msb ^ cout, i.e. two's-complement overflow.
  - ovf resets to 0 and is held like sum.
- Undefined: the port and the flop are absent; behaviour is otherwise identical.

## Structure
- Shared package / include `serial_adder_pkg`:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH constant.
- One sub-module, `serial_fa_bit`:
  - Combinational one-bit full adder with inputs a, b, ci and outputs s, co.
  - Built from gate primitives, instantiated once.
- Top level holds the FSM, the shift registers, the carry flop and the counter.

## Test plan
1. WIDTH=8, a=0x5A, b=0x3C, cin=0, done_ready=1:
   - done_valid rises 8 cycles after accept.
   - sum=0x96, cout=0.
2. a=0xFF, b=0x01, cin=0: sum=0x00, cout=1. Then a=0x00, b=0xFF, cin=1: sum=0x00, cout=1.
3. Backpressure:
   - a=0x12, b=0x34, done_ready held 0 for 5 cycles after done_valid.
   - sum stays 0x46 and done_valid stays 1.
   - start_valid asserted during this window is not accepted.
   - Release done_ready: IDLE next cycle.
4. Reset in RUN:
   - Assert rst at RUN cycle 3 of a=0xAA, b=0x55.
   - Outputs go to reset values immediately.
   - A new start with a=0x01, b=0x01 gives sum=0x02.
5. Back-to-back with done_ready=1 and start_valid=1 continuously: successive accepts are exactly 10 cycles apart for WIDTH=8.
6. With SERIAL_ADDER_OVF_EN:
   - a=0x7F, b=0x01 gives sum=0x80, ovf=1, cout=0.
   - a=0xFF, b=0x01 gives ovf=0, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state codes and default width.
package serial_adder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake bundle for serial_adder; the ovf signal exists only
// when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             done_valid;
    logic             done_ready;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output start_valid, a, b, cin, done_ready,
        input  start_ready, sum, cout, done_valid, ovf
    );
    modport slave (
        input  start_valid, a, b, cin, done_ready,
        output start_ready, sum, cout, done_valid, ovf
    );
`else
    modport master (
        output start_valid, a, b, cin, done_ready,
        input  start_ready, sum, cout, done_valid
    );
    modport slave (
        input  start_valid, a, b, cin, done_ready,
        output start_ready, sum, cout, done_valid
    );
`endif

endinterface

// File: rtl/serial_fa_bit.sv
// One-bit full adder built from gate primitives; purely combinational.
module serial_fa_bit (
    input  wire a,
    input  wire b,
    input  wire ci,
    output wire s,
    output wire co
);

    wire ab_x;
    wire ab_a;
    wire cx_a;

    xor g_x0 (ab_x, a, b);
    xor g_x1 (s, ab_x, ci);
    and g_a0 (ab_a, a, b);
    and g_a1 (cx_a, ab_x, ci);
    or  g_o0 (co, ab_a, cx_a);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH cycles from start accept to done_valid, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             carry_q,  carry_d;
    logic             cout_q,   cout_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             fa_s;
    logic             fa_co;
    logic             last_step;
    logic             in_done;
`ifdef SERIAL_ADDER_OVF_EN
    logic             cmsb_q,   cmsb_d;
    logic             ovf_q,    ovf_d;
`endif

    serial_fa_bit u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_step = (cnt_q == CW'(WIDTH - 1));
    assign in_done   = (state_q == DONE);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        cmsb_d   = cmsb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    carry_d  = bus.cin;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                carry_d  = fa_co;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (last_step) begin
                    state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
                    cmsb_d  = carry_q;
`endif
                end
            end
            DONE: begin
                // Latch the result on exit so outputs hold it once the next load clears sum_sh.
                if (bus.done_ready) begin
                    sum_d   = sum_sh_q;
                    cout_d  = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = cmsb_q ^ carry_q;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            cmsb_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            cmsb_q   <= cmsb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.done_valid  = in_done;
    assign bus.sum         = in_done ? sum_sh_q : sum_q;
    assign bus.cout        = in_done ? carry_q  : cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf         = in_done ? (cmsb_q ^ carry_q) : ovf_q;
`endif

endmodule
